// File: rtl/dvp_capture.sv
// DVP 8-bit camera capture to an RGB565 stream, with settle-frame skipping and line/frame size checks.
// Optional macro DVP_CAPTURE_PATTERN_EN replaces pixel data with 8 vertical colour bars.
module dvp_capture #(
    parameter logic [11:0] H_DISP      = 12'd1280,
    parameter logic [11:0] V_DISP      = 12'd720,
    parameter logic [3:0]  SKIP_FRAMES = 4'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        vi_vs,
    output logic        vi_de,
    output logic [15:0] vi_data,
    output logic [7:0]  frame_cnt,
    output logic        line_err
);
    typedef enum logic [1:0] {IDLE, SKIP, RUN} state_t;
    state_t state, state_next;

    logic        vs1, href1, vs2, href2;
    logic [7:0]  data1, hi_byte;
    logic [3:0]  skip_cnt, skip_cnt_next;
    logic        toggle;
    logic [11:0] x_cnt, y_cnt, y_at_fs;
    logic        frame_start, href_fall, active, pair_done, x_err, y_err;
    logic [15:0] pixel;

    assign frame_start = vs1 & ~vs2;
    assign href_fall   = href2 & ~href1;
    assign active      = (state == RUN) && en;
    assign pair_done   = active && href1 && toggle;
    // A pending odd byte at line end also means the line had the wrong length.
    assign x_err       = active && href_fall && ((x_cnt != H_DISP) || toggle);
    assign y_at_fs     = (active && href_fall && (y_cnt != 12'hFFF)) ? y_cnt + 12'd1 : y_cnt;
    assign y_err       = active && frame_start && (y_at_fs != V_DISP);

    always_comb begin
        state_next    = state;
        skip_cnt_next = skip_cnt;
        if (!en) begin
            state_next = IDLE;
        end else if (frame_start) begin
            case (state)
                IDLE: begin
                    if (SKIP_FRAMES == 4'd0) begin
                        state_next = RUN;
                    end else begin
                        state_next    = SKIP;
                        skip_cnt_next = 4'd0;
                    end
                end
                SKIP: begin
                    if (skip_cnt == SKIP_FRAMES) state_next = RUN;
                    else skip_cnt_next = skip_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DVP_CAPTURE_PATTERN_EN
    localparam logic [11:0] BAR_W = (H_DISP < 12'd8) ? 12'd1 : H_DISP / 12'd8;
    logic [11:0] bar;
    always_comb begin
        bar = x_cnt / BAR_W;
        case (bar)
            12'd0:   pixel = 16'hFFFF;
            12'd1:   pixel = 16'hFFE0;
            12'd2:   pixel = 16'h07FF;
            12'd3:   pixel = 16'h07E0;
            12'd4:   pixel = 16'hF81F;
            12'd5:   pixel = 16'hF800;
            12'd6:   pixel = 16'h001F;
            default: pixel = 16'h0000;
        endcase
    end
`else
    assign pixel = {hi_byte, data1};
`endif

    always_ff @(posedge clk) begin
        // NOTE: data-path registers are reset too, so no stale byte can leak out after rst.
        if (rst) begin
            vs1       <= 1'b0;
            href1     <= 1'b0;
            data1     <= 8'h00;
            vs2       <= 1'b0;
            href2     <= 1'b0;
            state     <= IDLE;
            skip_cnt  <= 4'd0;
            toggle    <= 1'b0;
            hi_byte   <= 8'h00;
            x_cnt     <= 12'd0;
            y_cnt     <= 12'd0;
            vi_vs     <= 1'b0;
            vi_de     <= 1'b0;
            vi_data   <= 16'h0000;
            frame_cnt <= 8'd0;
            line_err  <= 1'b0;
        end else begin
            vs1      <= cam_vsync;
            href1    <= cam_href;
            data1    <= cam_data;
            vs2      <= vs1;
            href2    <= href1;
            state    <= state_next;
            skip_cnt <= skip_cnt_next;

            vi_vs <= vs1 && (state_next == RUN);
            vi_de <= pair_done;
            if (pair_done) vi_data <= pixel;

            if (!active || href_fall) toggle <= 1'b0;
            else if (href1) toggle <= ~toggle;
            if (active && href1 && !toggle) hi_byte <= data1;

            if (!active || href_fall) x_cnt <= 12'd0;
            else if (pair_done && (x_cnt != 12'hFFF)) x_cnt <= x_cnt + 12'd1;

            if (!active || frame_start) y_cnt <= 12'd0;
            else if (href_fall && (y_cnt != 12'hFFF)) y_cnt <= y_cnt + 12'd1;

            if (frame_start && (state_next == RUN)) begin
                frame_cnt <= frame_cnt + 8'd1;
                line_err  <= x_err || y_err;
            end else if (x_err) begin
                line_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture (H_DISP=4, V_DISP=2, SKIP_FRAMES=2): skip sequence, byte pairing,
// size errors, enable drop and reset; a second H_DISP=16 instance covers the colour-bar build.
`timescale 1ns/1ps
module tb_dvp_capture;
    logic        clk = 1'b0;
    logic        rst, en, cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic        vi_vs, vi_de, line_err;
    logic [15:0] vi_data;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad   = 0;
    int de_seen = 0;
    logic [15:0] got[$];

    typedef struct {
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic        evs;
        logic        ede;
        logic [15:0] edata;
        logic        eerr;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    dvp_capture #(.H_DISP(12'd4), .V_DISP(12'd2), .SKIP_FRAMES(4'd2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .vi_vs(vi_vs), .vi_de(vi_de), .vi_data(vi_data),
        .frame_cnt(frame_cnt), .line_err(line_err)
    );

    always @(negedge clk) begin
        if (vi_de) begin
            de_seen++;
            got.push_back(vi_data);
        end
    end

`ifdef DVP_CAPTURE_PATTERN_EN
    logic        pat_vs, pat_de, pat_err;
    logic [15:0] pat_data;
    logic [7:0]  pat_fcnt;
    logic [15:0] pat_got[$];
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_capture #(.H_DISP(12'd16), .V_DISP(12'd1), .SKIP_FRAMES(4'd0)) dut_pat (
        .clk(clk), .rst(rst), .en(en),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .vi_vs(pat_vs), .vi_de(pat_de), .vi_data(pat_data),
        .frame_cnt(pat_fcnt), .line_err(pat_err)
    );

    always @(negedge clk) begin
        if (pat_de) pat_got.push_back(pat_data);
    end
`endif

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic vs, input logic hr, input logic [7:0] d,
                                input logic evs, input logic ede, input logic [15:0] edata,
                                input logic eerr);
        vec_t v;
        v = '{vs, hr, d, evs, ede, edata, eerr};
        tbl.push_back(v);
    endfunction

    // One frame: 2 lines of 8 bytes (4 pixels each), byte k of line l = base + 8*l + k.
    task automatic frame(input logic [7:0] base);
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 8'(base + 8'(8 * l + k)));
            repeat (3) cyc(1'b0, 1'b0, 8'h00);
        end
    endtask

    // Four frames after arming: the first three produce nothing, the fourth produces 8 pixels.
    task automatic run_frames(input string tag, input logic [7:0] base);
        int n0;
        int q0;
        logic [7:0]  fb;
        logic [15:0] a;
        logic [15:0] e;
        n0 = 0;
        q0 = 0;
        fb = base;
        for (int f = 1; f <= 4; f++) begin
            n0 = de_seen;
            q0 = got.size();
            fb = 8'(base + 8'(16 * f));
            frame(fb);
            check($sformatf("%s frame%0d de_count", tag, f), 32'(de_seen - n0),
                  (f < 4) ? 32'd0 : 32'd8);
        end
`ifndef DVP_CAPTURE_PATTERN_EN
        for (int j = 0; j < 8; j++) begin
            e = {8'(fb + 8'(8 * (j / 4) + 2 * (j % 4))), 8'(fb + 8'(8 * (j / 4) + 2 * (j % 4) + 1))};
            a = (q0 + j < got.size()) ? got[q0 + j] : 16'hxxxx;
            check($sformatf("%s pixel%0d", tag, j), 32'(a), 32'(e));
        end
`endif
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        check("reset vi_vs", 32'(vi_vs), 32'd0);
        check("reset vi_de", 32'(vi_de), 32'd0);
        check("reset vi_data", 32'(vi_data), 32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset line_err", 32'(line_err), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);

        // Skip sequence: 2 skipped frames plus the arming frame, then output.
        run_frames("skip", 8'h00);
        check("skip frame_cnt", 32'(frame_cnt), 32'd1);
        check("skip line_err", 32'(line_err), 32'd0);

        // Frame in RUN: good line starting F8,1F; then a 9-byte line; then a clean frame start.
        add(1, 0, 8'h00, 0, 0, 16'h0000, 0);
        add(1, 0, 8'h00, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 0);
        add(0, 1, 8'hF8, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h1F, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h12, 0, 1, 16'hF81F, 0);
        add(0, 1, 8'h34, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h56, 0, 1, 16'h1234, 0);
        add(0, 1, 8'h78, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h9A, 0, 1, 16'h5678, 0);
        add(0, 1, 8'hBC, 0, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 1, 16'h9ABC, 0);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h01, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h02, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h03, 0, 1, 16'h0102, 0);
        add(0, 1, 8'h04, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h05, 0, 1, 16'h0304, 0);
        add(0, 1, 8'h06, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h07, 0, 1, 16'h0506, 0);
        add(0, 1, 8'h08, 0, 0, 16'h0000, 0);
        add(0, 1, 8'h09, 0, 1, 16'h0708, 0);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 1);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 1);
        add(1, 0, 8'h00, 0, 0, 16'h0000, 1);
        add(1, 0, 8'h00, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].vs, tbl[i].hr, tbl[i].d);
            check($sformatf("row%0d vi_vs", i), 32'(vi_vs), 32'(tbl[i].evs));
            check($sformatf("row%0d vi_de", i), 32'(vi_de), 32'(tbl[i].ede));
            check($sformatf("row%0d line_err", i), 32'(line_err), 32'(tbl[i].eerr));
`ifndef DVP_CAPTURE_PATTERN_EN
            if (tbl[i].ede) check($sformatf("row%0d vi_data", i), 32'(vi_data), 32'(tbl[i].edata));
`endif
        end
        check("table frame_cnt", 32'(frame_cnt), 32'd3);

        // Enable dropped exactly when a pair would complete.
        cyc(1'b0, 1'b1, 8'hA1);
        cyc(1'b0, 1'b1, 8'hA2);
        cyc(1'b0, 1'b1, 8'hA3);
        check("en pair before drop", 32'(vi_de), 32'd1);
        cyc(1'b0, 1'b1, 8'hA4);
        en = 1'b0;
        n0 = de_seen;
        cyc(1'b0, 1'b1, 8'hA5);
        check("en drop vi_de", 32'(vi_de), 32'd0);
        cyc(1'b0, 1'b1, 8'hA6);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        check("en drop no pixels", 32'(de_seen - n0), 32'd0);
        en = 1'b1;
        run_frames("reen", 8'h40);
        check("reen frame_cnt", 32'(frame_cnt), 32'd4);
        check("reen line_err", 32'(line_err), 32'd0);

        // Reset pulsed mid-line in RUN, on the cycle a pixel would appear.
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'hC1);
        cyc(1'b0, 1'b1, 8'hC2);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 8'hC3);
        check("rst vi_de", 32'(vi_de), 32'd0);
        check("rst vi_vs", 32'(vi_vs), 32'd0);
        check("rst vi_data", 32'(vi_data), 32'd0);
        check("rst frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst line_err", 32'(line_err), 32'd0);
        rst = 1'b0;
        n0 = de_seen;
        cyc(1'b0, 1'b1, 8'hC4);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        check("rst partial line silent", 32'(de_seen - n0), 32'd0);
        run_frames("rst", 8'h80);
        check("rst frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef DVP_CAPTURE_PATTERN_EN
        begin
            int p0;
            logic [15:0] a;
            rst = 1'b1;
            cyc(1'b0, 1'b0, 8'h00);
            rst = 1'b0;
            p0 = pat_got.size();
            repeat (2) cyc(1'b1, 1'b0, 8'h00);
            repeat (2) cyc(1'b0, 1'b0, 8'h00);
            for (int k = 0; k < 32; k++) cyc(1'b0, 1'b1, 8'(k));
            repeat (3) cyc(1'b0, 1'b0, 8'h00);
            check("pattern count", 32'(pat_got.size() - p0), 32'd16);
            for (int j = 0; j < 16; j++) begin
                a = (p0 + j < pat_got.size()) ? pat_got[p0 + j] : 16'hxxxx;
                check($sformatf("pattern pixel%0d", j), 32'(a), 32'(bars[j / 2]));
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
